// File: rtl/armv8_pkg.sv
// Types and constants shared by the ARMv8 pipeline stages (fetch, decode, hazard unit).
package armv8_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'hD503201F;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instruction;
        logic               valid;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

endpackage

// File: rtl/fetch_stage_if.sv
// Control inputs and IF/ID-facing outputs of the fetch stage.
interface fetch_stage_if;
    import armv8_pkg::*;

    logic                stall;
    logic                branch_taken;
    logic [ADDR_W-1:0]   branch_target;
    logic [ADDR_W-1:0]   pc_out;
    logic [ADDR_W-1:0]   if_id_pc;
    logic [INSTR_W-1:0]  if_id_instruction;
    logic                if_id_valid;
    logic [31:0]         fetch_count;

    // master: the fetch stage itself; slave: hazard/execute control and decode.
    modport master (
        input  stall, branch_taken, branch_target,
        output pc_out, if_id_pc, if_id_instruction, if_id_valid, fetch_count
    );

    modport slave (
        output stall, branch_taken, branch_target,
        input  pc_out, if_id_pc, if_id_instruction, if_id_valid, fetch_count
    );

endinterface

// File: rtl/if_id_register.sv
// Pipeline flop bundle with reset > flush > hold > load priority.
module if_id_register #(
    parameter int           W      = 1,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         hold_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (flush_i) begin
            data_d = BUBBLE;
        end else if (!hold_i) begin
            data_d = d_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= BUBBLE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, read-only instruction memory and the IF/ID register feeding decode.
import armv8_pkg::*;

module fetch_stage #(
    parameter int                  IMEM_WORDS = 64,
    parameter logic [ADDR_W-1:0]   RESET_PC   = 64'h0,
    parameter logic [INSTR_W-1:0]  NOP_WORD   = armv8_pkg::NOP_WORD
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.master fif
);

    localparam int IDX_W = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam logic [IF_ID_W-1:0] BUBBLE = {{ADDR_W{1'b0}}, NOP_WORD, 1'b0};

    // Populated by the environment; there is no write port.
    logic [INSTR_W-1:0] memory [IMEM_WORDS];

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [31:0]        count_q, count_d;
    logic [ADDR_W-3:0]  word_idx;
    logic               in_range;
    logic [INSTR_W-1:0] fetch_word;
    if_id_t             if_id_d, if_id_q;

    assign word_idx   = pc_q[ADDR_W-1:2];
    assign in_range   = word_idx < (ADDR_W-2)'(IMEM_WORDS);
    assign fetch_word = in_range ? memory[word_idx[IDX_W-1:0]] : NOP_WORD;

    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        if (fif.branch_taken) begin
            pc_d = fif.branch_target & ~64'h3;
        end else if (!fif.stall) begin
            pc_d    = pc_q + 64'd4;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        if_id_d             = '0;
        if_id_d.pc          = pc_q;
        if_id_d.instruction = fetch_word;
        if_id_d.valid       = 1'b1;
    end

    if_id_register #(
        .W      (IF_ID_W),
        .BUBBLE (BUBBLE)
    ) u_if_id (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (fif.branch_taken),
        .hold_i  (fif.stall),
        .d_i     (if_id_d),
        .q_o     (if_id_q)
    );

    assign fif.pc_out            = pc_q;
    assign fif.if_id_pc          = if_id_q.pc;
    assign fif.if_id_instruction = if_id_q.instruction;
    assign fif.if_id_valid       = if_id_q.valid;
    assign fif.fetch_count       = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, sequencing, stall, flush, out-of-range and wrap cases.
module tb_fetch_stage;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    fetch_stage_if fif ();

    fetch_stage #(
        .IMEM_WORDS (64),
        .RESET_PC   (64'h0),
        .NOP_WORD   (32'hD503201F)
    ) dut (
        .clock (clock),
        .reset (reset),
        .fif   (fif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_memory();
        for (int i = 0; i < 64; i++) dut.memory[i] = 32'h1000_0000 + i;
        dut.memory[0] = 32'h8B120202;
        dut.memory[1] = 32'hCB120202;
        dut.memory[2] = 32'h8A120202;
    endtask

    task automatic expect_state(input string tag, input logic [63:0] pc,
                                input logic [63:0] ipc, input logic [31:0] instr,
                                input logic vld, input logic [31:0] cnt);
        checks++;
        if (fif.pc_out !== pc) begin
            errors++; $display("FAIL %s pc_out got %h want %h", tag, fif.pc_out, pc);
        end
        checks++;
        if (fif.if_id_pc !== ipc) begin
            errors++; $display("FAIL %s if_id_pc got %h want %h", tag, fif.if_id_pc, ipc);
        end
        checks++;
        if (fif.if_id_instruction !== instr) begin
            errors++; $display("FAIL %s instr got %h want %h", tag, fif.if_id_instruction, instr);
        end
        checks++;
        if (fif.if_id_valid !== vld) begin
            errors++; $display("FAIL %s valid got %b want %b", tag, fif.if_id_valid, vld);
        end
        checks++;
        if (fif.fetch_count !== cnt) begin
            errors++; $display("FAIL %s fetch_count got %0d want %0d", tag, fif.fetch_count, cnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        fif.stall = 1'b0; fif.branch_taken = 1'b0; fif.branch_target = '0;
        tick();
        expect_state("reset", 64'h0, 64'h0, 32'hD503201F, 1'b0, 32'd0);
    endtask

    task automatic test_sequencing();
        logic [31:0] exp_instr [3];
        exp_instr[0] = 32'h8B120202;
        exp_instr[1] = 32'hCB120202;
        exp_instr[2] = 32'h8A120202;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_state($sformatf("seq%0d", i), 64'(4 * (i + 1)), 64'(4 * i),
                         exp_instr[i], 1'b1, 32'(i + 1));
        end
    endtask

    task automatic test_stall();
        reset = 1'b1; tick(); reset = 1'b0;
        tick(); tick();
        expect_state("pre_stall", 64'h8, 64'h4, 32'hCB120202, 1'b1, 32'd2);
        fif.stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_state($sformatf("stall%0d", i), 64'h8, 64'h4, 32'hCB120202, 1'b1, 32'd2);
        end
        fif.stall = 1'b0;
        tick();
        expect_state("post_stall", 64'hC, 64'h8, 32'h8A120202, 1'b1, 32'd3);
        tick();
        expect_state("seq3", 64'h10, 64'hC, 32'h1000_0003, 1'b1, 32'd4);
    endtask

    task automatic test_branch_flush();
        fif.branch_taken = 1'b1; fif.branch_target = 64'h1B;
        tick();
        expect_state("flush", 64'h18, 64'h0, 32'hD503201F, 1'b0, 32'd4);
        fif.branch_taken = 1'b0; fif.branch_target = '0;
        tick();
        expect_state("target", 64'h1C, 64'h18, 32'h1000_0006, 1'b1, 32'd5);
    endtask

    task automatic test_branch_and_stall();
        fif.branch_taken = 1'b1; fif.stall = 1'b1; fif.branch_target = 64'h4;
        tick();
        expect_state("br_stall", 64'h4, 64'h0, 32'hD503201F, 1'b0, 32'd5);
        fif.branch_taken = 1'b0; fif.stall = 1'b0;
        tick();
        expect_state("br_stall_tgt", 64'h8, 64'h4, 32'hCB120202, 1'b1, 32'd6);
    endtask

    task automatic test_out_of_range();
        fif.branch_taken = 1'b1; fif.branch_target = 64'hFC;
        tick();
        fif.branch_taken = 1'b0;
        tick();
        expect_state("last_word", 64'h100, 64'hFC, 32'h1000_003F, 1'b1, 32'd7);
        tick();
        expect_state("oor", 64'h104, 64'h100, 32'hD503201F, 1'b1, 32'd8);
    endtask

    task automatic test_pc_wrap();
        fif.branch_taken = 1'b1; fif.branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        expect_state("wrap_flush", 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 32'hD503201F, 1'b0, 32'd8);
        fif.branch_taken = 1'b0;
        tick();
        expect_state("wrap", 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 32'hD503201F, 1'b1, 32'd9);
    endtask

    task automatic test_reset_during_flush();
        tick();
        reset = 1'b1; fif.branch_taken = 1'b1; fif.stall = 1'b1; fif.branch_target = 64'h40;
        tick();
        expect_state("rst_flush", 64'h0, 64'h0, 32'hD503201F, 1'b0, 32'd0);
        reset = 1'b0; fif.branch_taken = 1'b0; fif.stall = 1'b0;
        tick();
        expect_state("rst_first", 64'h4, 64'h0, 32'h8B120202, 1'b1, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        load_memory();
        test_reset();
        test_sequencing();
        test_stall();
        test_branch_flush();
        test_branch_and_stall();
        test_out_of_range();
        test_pc_wrap();
        test_reset_during_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined ARMv8 core, directly upstream of instruction decode.
- Holds the PC and the instruction memory.
- Drives the IF/ID pipeline register consumed by decode.
- Accepts stall from hazard detection and branch redirect/flush from the execute stage (B, CBZ, BR).

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words.
RESET_PC, 64'h0, PC value loaded on reset.
NOP_WORD, 32'hD503201F, ARMv8 NOP; used for bubbles and out-of-range fetches.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
stall  input  1  hold PC and IF/ID contents.
branch_taken  input  1  redirect PC and flush IF/ID.
branch_target  input  64  byte address of the redirect target.
pc_out  output  64  current fetch PC.
if_id_pc  output  64  PC of the instruction held in IF/ID.
if_id_instruction  output  32  instruction word held in IF/ID.
if_id_valid  output  1  IF/ID holds a real instruction, not a bubble.
fetch_count  output  32  count of instructions entered into IF/ID.

Behaviour:
- Memory array name is `memory`, 32-bit x IMEM_WORDS, word-indexed.
  - Loaded by `$readmemh` from benches; no write port.
  - Read is combinational at index PC[63:2].
- Out-of-range fetch (PC[63:2] >= IMEM_WORDS): fetched word = NOP_WORD, still valid, PC keeps advancing.
- PC arithmetic: 64-bit, next = PC + 4, wraps modulo 2^64.
- branch_target[1:0] are forced to 0 when loaded into PC.
- Every edge evaluates one case, highest priority first:
  1. reset: PC <= RESET_PC; if_id_pc <= 0; if_id_instruction <= NOP_WORD; if_id_valid <= 0; fetch_count <= 0.
  2. branch_taken, regardless of stall:
     - PC <= {branch_target[63:2], 2'b00}.
     - IF/ID flushed: instruction NOP_WORD, valid 0, pc 0.
     - fetch_count unchanged.
  3. stall: PC, IF/ID and fetch_count all hold.
  4. normal:
     - IF/ID <= {PC, memory word at PC, valid 1}.
     - PC <= PC + 4.
     - fetch_count += 1, wraps at 2^32.
- Latency: an instruction at address A appears in IF/ID one edge after pc_out = A with stall low.
- First edge after reset deasserts latches the word at RESET_PC.
- The target instruction reaches IF/ID two edges after branch_taken is sampled (flush edge, then fetch edge).
- Reset asserted mid-stall or mid-branch: reset wins and all state is cleared the same edge.
- No combinational path from any input to any output; every output comes from a register.

Decomposition:
- Shared package `armv8_pkg`: NOP_WORD, INSTR_W = 32, ADDR_W = 64, and the IF/ID bundle typedef {pc, instruction, valid}.
- Decode and the hazard unit reuse the same package.
- One natural sub-module: `if_id_register`, a flop bundle with hold/flush/reset priority.
  - It is reused later for ID/EX with a different payload width.

Test Plan:
- Reset sequencing: memory[0..2] = 8B120202, CB120202, 8A120202; reset high 1 cycle, then low.
  - Next three edges give IF/ID instruction 8B120202, CB120202, 8A120202.
  - if_id_pc = 0, 4, 8; pc_out = 4, 8, 12; fetch_count = 1, 2, 3.
- Stall: stall high 2 cycles while pc_out = 8.
  - pc_out stays 8, IF/ID holds CB120202 valid, fetch_count holds.
  - Next non-stalled edge loads 8A120202.
- Branch flush: branch_taken = 1, target = 0x1B (pc_out = 0x10).
  - Next edge: pc_out = 0x18, if_id_valid = 0, instruction D503201F.
  - Following edge: instruction memory[6] with if_id_pc = 0x18.
- Branch and stall together, target 0x4: branch wins.
  - pc_out = 4, IF/ID flushed, fetch_count unchanged.
- Out-of-range fetch: IMEM_WORDS = 64, branch to 0x100.
  - IF/ID = D503201F with valid 1 and if_id_pc = 0x100; pc_out advances to 0x104.
- Reset during a flush: assert reset on the same edge as branch_taken.
  - pc_out = RESET_PC, if_id_valid = 0, fetch_count = 0.
